// File: rtl/dataout_pio_pkg.sv
// Shared types and constants for the DataOut PIO arbiter slice.
// Holds the FSM state encoding and PIO register map constants.
package dataout_pio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READBACK,
    HOLD
  } state_e;

  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
  localparam int         PIO_W         = 16;

endpackage

// File: rtl/dataout_pio_arbiter_rr.sv
// Round-robin picker: first asserted req searching upward from ptr+1.
// The doubled request vector makes the modulo wrap a plain index.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [1:0]         grant_idx,
  output logic               grant_vld
);

  localparam logic [2:0] NR = 3'(NUM_REQ);

  logic [7:0] w_req2;
  logic [2:0] w_pos;

  assign w_req2 = 8'({req, req});

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    w_pos     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_pos = {1'b0, ptr} + 3'(k);
      if (w_req2[w_pos]) begin
        grant_vld = 1'b1;
        grant_idx = (w_pos >= NR) ? 2'(w_pos - NR)
                                  : w_pos[1:0];
      end
    end
  end

endmodule

// File: rtl/dataout_pio_arbiter.sv
// Avalon-MM master sharing the DataOut PIO between NUM_REQ requesters.
// Define DATAOUT_PIO_ARBITER_READBACK_EN to verify each write by readback.
module dataout_pio_arbiter
  import dataout_pio_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int DATA_W      = 16,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [1:0]                pio_address,
  output logic                      pio_chipselect,
  output logic                      pio_write_n,
  output logic [31:0]               pio_writedata,
  input  logic [31:0]               pio_readdata,
  output logic                      busy,
  output logic [1:0]                last_grant,
  output logic                      mismatch,
  input  logic                      mismatch_clr
);

`ifdef DATAOUT_PIO_ARBITER_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif
  localparam bit HAS_HOLD = (HOLD_CYCLES > 0);
  localparam logic [7:0] HOLD_M1 =
    8'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  state_e            r_state;
  state_e            w_next;
  logic [7:0]        r_cnt;
  logic [1:0]        r_last;
  logic [DATA_W-1:0] r_wr_data;
  logic [DATA_W-1:0] w_word;
  logic              r_cs;
  logic              r_wn;
  logic              w_cs_d;
  logic              w_wn_d;
  logic              w_hs;
  logic [1:0]        w_gidx;
  logic              w_gvld;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req       (req_valid),
    .ptr       (r_last),
    .grant_idx (w_gidx),
    .grant_vld (w_gvld)
  );

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (r_state == IDLE) && w_gvld &&
                     (w_gidx == 2'(i));
    end
  end

  assign w_hs   = |req_ready;
  assign w_word = req_data[int'(w_gidx)*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     if (w_hs) w_next = WRITE;
      WRITE:    w_next = RB_EN    ? READBACK :
                         HAS_HOLD ? HOLD : IDLE;
      READBACK: w_next = HAS_HOLD ? HOLD : IDLE;
      HOLD:     if (r_cnt == 8'd0) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Bus strobes are decoded from the next state so they leave a flop.
  always_comb begin
    w_cs_d = (w_next == WRITE) || (w_next == READBACK);
    w_wn_d = (w_next != WRITE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cs      <= 1'b0;
      r_wn      <= 1'b1;
      r_cnt     <= '0;
      r_last    <= '0;
      r_wr_data <= '0;
    end else begin
      r_cs <= w_cs_d;
      r_wn <= w_wn_d;
      if (w_hs) begin
        r_wr_data <= w_word;
        r_last    <= w_gidx;
      end
      if (r_state != HOLD && w_next == HOLD) begin
        r_cnt <= HOLD_M1;
      end else if (r_state == HOLD && r_cnt != 8'd0) begin
        r_cnt <= r_cnt - 8'd1;
      end
    end
  end

`ifdef DATAOUT_PIO_ARBITER_READBACK_EN
  logic r_mis;
  logic w_mis_evt;
  logic w_unused;

  assign w_mis_evt = (r_state == READBACK) &&
                     (pio_readdata[PIO_W-1:0] != r_wr_data);
  assign w_unused  = ^pio_readdata[31:PIO_W];

  // A fresh mismatch outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mis <= 1'b0;
    end else if (w_mis_evt) begin
      r_mis <= 1'b1;
    end else if (mismatch_clr) begin
      r_mis <= 1'b0;
    end
  end

  assign mismatch = r_mis;
`else
  logic w_unused;

  assign w_unused = ^{pio_readdata, mismatch_clr};
  assign mismatch = 1'b0;
`endif

  assign pio_address    = PIO_DATA_ADDR;
  assign pio_chipselect = r_cs;
  assign pio_write_n    = r_wn;
  assign pio_writedata  = {{(32-DATA_W){1'b0}}, r_wr_data};
  assign busy           = (r_state != IDLE);
  assign last_grant     = r_last;

endmodule

// File: tb/tb_dataout_pio_arbiter.sv
// Bench for dataout_pio_arbiter: directed scenarios plus random traffic
// checked against a transaction-timing reference model.
module tb_dataout_pio_arbiter;

  localparam int NR   = 2;
  localparam int DW   = 16;
  localparam int HOLD = 4;
`ifdef DATAOUT_PIO_ARBITER_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif
  localparam int GAP  = 2 + HOLD + RB;
  localparam int GAP0 = 2 + RB;

  int n_tests = 0;
  int n_fail  = 0;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*DW-1:0] req_data;
  logic [1:0]       pio_address;
  logic [1:0]       last_grant;
  logic             pio_chipselect;
  logic             pio_write_n;
  logic [31:0]      pio_writedata;
  logic [31:0]      pio_readdata;
  logic             busy;
  logic             mismatch;
  logic             mismatch_clr;
  logic [15:0]      out_port;
  logic             force_zero;

  logic [NR-1:0]    b_valid;
  logic [NR-1:0]    b_ready;
  logic [NR*DW-1:0] b_data;
  logic [1:0]       b_addr;
  logic [1:0]       b_last;
  logic             b_cs;
  logic             b_wn;
  logic [31:0]      b_wdata;
  logic [31:0]      b_rdata;
  logic             b_busy;
  logic             b_mis;
  logic [15:0]      b_out;

  dataout_pio_arbiter #(
    .NUM_REQ (NR), .DATA_W (DW), .HOLD_CYCLES (HOLD)
  ) u_dut (
    .clk (clk), .reset_n (reset_n),
    .req_valid (req_valid), .req_data (req_data),
    .req_ready (req_ready), .pio_address (pio_address),
    .pio_chipselect (pio_chipselect), .pio_write_n (pio_write_n),
    .pio_writedata (pio_writedata), .pio_readdata (pio_readdata),
    .busy (busy), .last_grant (last_grant),
    .mismatch (mismatch), .mismatch_clr (mismatch_clr)
  );

  dataout_pio_arbiter #(
    .NUM_REQ (NR), .DATA_W (DW), .HOLD_CYCLES (0)
  ) u_dut0 (
    .clk (clk), .reset_n (reset_n),
    .req_valid (b_valid), .req_data (b_data),
    .req_ready (b_ready), .pio_address (b_addr),
    .pio_chipselect (b_cs), .pio_write_n (b_wn),
    .pio_writedata (b_wdata), .pio_readdata (b_rdata),
    .busy (b_busy), .last_grant (b_last),
    .mismatch (b_mis), .mismatch_clr (mismatch_clr)
  );

  // PIO slave models: out_port latches on a chipselected write.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_port <= 16'h0;
    else if (pio_chipselect && !pio_write_n) out_port <= pio_writedata[15:0];
  end
  assign pio_readdata = force_zero ? 32'h0 : {16'h0, out_port};

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) b_out <= 16'h0;
    else if (b_cs && !b_wn) b_out <= b_wdata[15:0];
  end
  assign b_rdata = {16'h0, b_out};

  task automatic do_reset();
    req_valid = '0; req_data = '0;
    b_valid = '0; b_data = '0;
    mismatch_clr = 1'b0; force_zero = 1'b0;
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b want 00", req_ready); end
    n_tests++; if (pio_chipselect !== 1'b0) begin n_fail++; $display("FAIL reset_cs got %b want 0", pio_chipselect); end
    n_tests++; if (pio_write_n !== 1'b1) begin n_fail++; $display("FAIL reset_wn got %b want 1", pio_write_n); end
    n_tests++; if (pio_writedata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", pio_writedata); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (last_grant !== 2'd0) begin n_fail++; $display("FAIL reset_last got %0d want 0", last_grant); end
    n_tests++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL reset_mis got %b want 0", mismatch); end
    n_tests++; if (pio_address !== 2'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", pio_address); end
  endtask

  task automatic test_single();
    int nb;
    int nw;
    do_reset();
    @(negedge clk);
    req_valid = 2'b01; req_data = {16'h0, 16'hA5A5};
    #1;
    n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready got %b want 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    n_tests++; if (pio_chipselect !== 1'b1) begin n_fail++; $display("FAIL single_cs got %b want 1", pio_chipselect); end
    n_tests++; if (pio_write_n !== 1'b0) begin n_fail++; $display("FAIL single_wn got %b want 0", pio_write_n); end
    n_tests++; if (pio_writedata !== 32'h0000A5A5) begin n_fail++; $display("FAIL single_wdata got %h want 0000a5a5", pio_writedata); end
    nb = int'(busy);
    nw = int'(!pio_write_n);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      nb += int'(busy);
      nw += int'(!pio_write_n);
    end
    n_tests++; if (nb != 1 + RB + HOLD) begin n_fail++; $display("FAIL single_busy got %0d want %0d", nb, 1 + RB + HOLD); end
    n_tests++; if (nw != 1) begin n_fail++; $display("FAIL single_nwrite got %0d want 1", nw); end
    n_tests++; if (out_port !== 16'hA5A5) begin n_fail++; $display("FAIL single_port got %h want a5a5", out_port); end
  endtask

  task automatic test_alternate();
    int n;
    int idx[4];
    int at[4];
    logic [31:0] exp_w;
    n = 0;
    do_reset();
    @(negedge clk);
    req_valid = 2'b11; req_data = {16'h0002, 16'h0001};
    for (int c = 0; c < 30; c++) begin
      #1;
      if (n > 0 && c == at[n-1] + 1) begin
        exp_w = ((n - 1) % 2 == 0) ? 32'h2 : 32'h1;
        n_tests++; if (pio_write_n !== 1'b0 || pio_writedata !== exp_w) begin n_fail++; $display("FAIL alt_write got wn=%b %h want %h", pio_write_n, pio_writedata, exp_w); end
        n_tests++; if (int'(last_grant) != ((n - 1) % 2 == 0 ? 1 : 0)) begin n_fail++; $display("FAIL alt_last got %0d at grant %0d", last_grant, n - 1); end
      end
      if (req_ready != '0 && n < 4) begin
        idx[n] = req_ready[1] ? 1 : 0;
        at[n] = c;
        n++;
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    n_tests++; if (n != 4) begin n_fail++; $display("FAIL alt_count got %0d want 4", n); end
    for (int k = 0; k < n; k++) begin
      n_tests++; if (idx[k] != ((k % 2 == 0) ? 1 : 0)) begin n_fail++; $display("FAIL alt_order grant %0d got %0d", k, idx[k]); end
      if (k > 0) begin
        n_tests++; if (at[k] - at[k-1] != GAP) begin n_fail++; $display("FAIL alt_gap got %0d want %0d", at[k] - at[k-1], GAP); end
      end
    end
  endtask

  task automatic test_hold0();
    logic [15:0] w;
    logic [15:0] w_prev;
    logic was_low;
    logic acc;
    int nst;
    int ncons;
    nst = 0; ncons = 0; was_low = 1'b0; w_prev = 16'h0;
    do_reset();
    @(negedge clk);
    w = 16'($urandom);
    b_valid = 2'b01; b_data = {16'h0, w};
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!b_wn) begin
        nst++;
        if (was_low) ncons++;
        n_tests++; if (b_wdata !== {16'h0, w_prev}) begin n_fail++; $display("FAIL h0_wdata got %h want %h", b_wdata, w_prev); end
      end
      was_low = !b_wn;
      w_prev = w;
      acc = b_ready[0];
      @(negedge clk);
      if (acc) begin
        w = 16'($urandom);
        b_data = {16'h0, w};
      end
    end
    b_valid = 2'b00;
    n_tests++; if (nst != (20 - 2) / GAP0 + 1) begin n_fail++; $display("FAIL h0_count got %0d want %0d", nst, (20 - 2) / GAP0 + 1); end
    n_tests++; if (ncons != 0) begin n_fail++; $display("FAIL h0_consec got %0d want 0", ncons); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    req_valid = 2'b01; req_data = {16'h0, 16'h5A5A};
    #1;
    n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rmid_ready got %b want 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    n_tests++; if (pio_chipselect !== 1'b1) begin n_fail++; $display("FAIL rmid_write got cs=%b want 1", pio_chipselect); end
    reset_n = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1) begin n_fail++; $display("FAIL rmid_bus got cs=%b wn=%b want 0 1", pio_chipselect, pio_write_n); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b want 0", busy); end
    n_tests++; if (out_port !== 16'h0) begin n_fail++; $display("FAIL rmid_port got %h want 0", out_port); end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    req_valid = 2'b11; req_data = {16'h2222, 16'h1111};
    #1;
    n_tests++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL rmid_regrant got %b want 10", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
  endtask

  task automatic test_drop();
    int n_r1;
    int n_beef;
    int n_0c;
    int acc_at;
    logic done;
    n_r1 = 0; n_beef = 0; n_0c = 0; acc_at = -1; done = 1'b0;
    do_reset();
    @(negedge clk);
    req_valid = 2'b01; req_data = {16'h0, 16'h1111};
    #1;
    n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL drop_first got %b want 01", req_ready); end
    for (int c = 1; c < GAP + 8; c++) begin
      @(negedge clk);
      if (done) req_valid = 2'b00;
      else if (c < GAP - 1) req_valid = 2'b11;
      else req_valid = 2'b01;
      req_data = {16'hBEEF, 16'h0C0C};
      #1;
      if (req_ready[1]) n_r1++;
      if (!pio_write_n && pio_writedata[15:0] == 16'hBEEF) n_beef++;
      if (!pio_write_n && pio_writedata[15:0] == 16'h0C0C) n_0c++;
      if (req_ready[0] && req_valid[0] && !done) begin
        done = 1'b1;
        acc_at = c;
      end
    end
    req_valid = 2'b00;
    n_tests++; if (n_r1 != 0) begin n_fail++; $display("FAIL drop_r1_ready got %0d want 0", n_r1); end
    n_tests++; if (n_beef != 0) begin n_fail++; $display("FAIL drop_beef got %0d want 0", n_beef); end
    n_tests++; if (n_0c != 1) begin n_fail++; $display("FAIL drop_0c0c got %0d want 1", n_0c); end
    n_tests++; if (acc_at != GAP) begin n_fail++; $display("FAIL drop_accept got %0d want %0d", acc_at, GAP); end
  endtask

  task automatic test_random();
    int m_ptr;
    int m_hs;
    int m_last;
    int win;
    int j;
    logic [15:0] m_word;
    logic [NR-1:0] exp_ready;
    logic [NR-1:0] acc;
    logic exp_strobe;
    logic exp_cs;
    logic exp_busy;
    m_ptr = 0; m_hs = -100; m_last = 0; m_word = 16'h0; win = 0;
    acc = '0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        if (!req_valid[i]) begin
          if ($urandom_range(2) == 0) begin
            req_valid[i] = 1'b1;
            req_data[i*DW +: DW] = 16'($urandom);
          end
        end else if ($urandom_range(9) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      #1;
      exp_ready = '0;
      if (c >= m_hs + GAP) begin
        for (int k = NR; k >= 1; k--) begin
          j = (m_ptr + k) % NR;
          if (req_valid[j]) begin
            exp_ready = '0;
            exp_ready[j] = 1'b1;
            win = j;
          end
        end
      end
      exp_strobe = (c == m_hs + 1);
      exp_cs = exp_strobe || (RB == 1 && c == m_hs + 2);
      exp_busy = (c >= m_hs + 1) && (c <= m_hs + GAP - 1);
      n_tests++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready c=%0d got %b want %b", c, req_ready, exp_ready); end
      n_tests++; if (pio_chipselect !== exp_cs) begin n_fail++; $display("FAIL rnd_cs c=%0d got %b want %b", c, pio_chipselect, exp_cs); end
      n_tests++; if (pio_write_n !== !exp_strobe) begin n_fail++; $display("FAIL rnd_wn c=%0d got %b want %b", c, pio_write_n, !exp_strobe); end
      n_tests++; if (busy !== exp_busy) begin n_fail++; $display("FAIL rnd_busy c=%0d got %b want %b", c, busy, exp_busy); end
      n_tests++; if (int'(last_grant) != m_last) begin n_fail++; $display("FAIL rnd_last c=%0d got %0d want %0d", c, last_grant, m_last); end
      n_tests++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL rnd_mis c=%0d got %b want 0", c, mismatch); end
      if (exp_strobe) begin
        n_tests++; if (pio_writedata !== {16'h0, m_word}) begin n_fail++; $display("FAIL rnd_wdata c=%0d got %h want %h", c, pio_writedata, m_word); end
      end
      if (exp_ready != '0) begin
        m_hs = c;
        m_ptr = win;
        m_last = win;
        m_word = req_data[win*DW +: DW];
      end
      acc = req_valid & req_ready;
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_mismatch();
    do_reset();
`ifdef DATAOUT_PIO_ARBITER_READBACK_EN
    force_zero = 1'b1;
    @(negedge clk);
    req_valid = 2'b01; req_data = {16'h0, 16'h1234};
    #1;
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk); #1;
    n_tests++; if (mismatch !== 1'b1) begin n_fail++; $display("FAIL mis_set got %b want 1", mismatch); end
    n_tests++; if (out_port !== 16'h1234) begin n_fail++; $display("FAIL mis_port got %h want 1234", out_port); end
    repeat (5) @(negedge clk);
    #1;
    n_tests++; if (mismatch !== 1'b1) begin n_fail++; $display("FAIL mis_sticky got %b want 1", mismatch); end
    @(negedge clk); mismatch_clr = 1'b1;
    @(negedge clk); mismatch_clr = 1'b0;
    #1;
    n_tests++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL mis_clr got %b want 0", mismatch); end
    force_zero = 1'b0;
`else
    @(negedge clk); mismatch_clr = 1'b1;
    @(negedge clk); mismatch_clr = 1'b0;
    #1;
    n_tests++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL mis_tied got %b want 0", mismatch); end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_hold0();
    test_reset_mid();
    test_drop();
    test_random();
    test_mismatch();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
